// File: rtl/subtree_report_collector.sv
// subtree_report_collector: round-robin fan-in of child report streams
// into one registered upstream slot, tagged with the source child index.
module subtree_report_collector #(
    parameter int NUM_CHILD = 5,
    parameter int DATA_W    = 16,
    parameter int IDX_W     = 3,
    parameter int CNT_W     = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CHILD-1:0]        child_valid,
    input  logic [NUM_CHILD*DATA_W-1:0] child_data,
    output logic [NUM_CHILD-1:0]        child_ready,
    output logic                        up_valid,
    output logic [DATA_W-1:0]           up_data,
    output logic [IDX_W-1:0]            up_src,
    input  logic                        up_ready,
    output logic [CNT_W-1:0]            fwd_count,
    output logic                        fwd_sat
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_e;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHILD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    slot_e             state;
    slot_e             state_nxt;
    logic [IDX_W-1:0]  last_grant;
    logic              load_ok;
    logic              win_found;
    logic [IDX_W-1:0]  win_idx;
    logic [DATA_W-1:0] win_data;
    logic              child_xfer;
    logic              up_xfer;
    logic [CNT_W-1:0]  cnt_next;

    // Slot can accept when empty or when it drains this same cycle.
    assign load_ok    = (state == EMPTY) || up_ready;
    assign up_xfer    = (state == FULL) && up_ready;
    assign child_xfer = win_found && load_ok;

    // Round-robin scan: first valid child after last_grant wins.
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int k = 1; k <= NUM_CHILD; k++) begin
            idx = (int'(last_grant) + k) % NUM_CHILD;
            for (int i = 0; i < NUM_CHILD; i++) begin
                if (!win_found && (idx == i) && child_valid[i]) begin
                    win_found = 1'b1;
                    win_idx   = IDX_W'(i);
                end
            end
        end
    end

    // Winner data mux and one-hot accept to the winner only.
    always_comb begin
        win_data    = '0;
        child_ready = '0;
        for (int i = 0; i < NUM_CHILD; i++) begin
            if (win_idx == IDX_W'(i)) begin
                win_data = child_data[i*DATA_W +: DATA_W];
            end
            child_ready[i] = load_ok && win_found &&
                             (win_idx == IDX_W'(i));
        end
    end

    // Slot occupancy register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Slot next state: refill wins over drain.
    always_comb begin
        state_nxt = state;
        if (child_xfer) begin
            state_nxt = FULL;
        end else if (up_xfer) begin
            state_nxt = EMPTY;
        end
    end

    // Slot output decode.
    always_comb begin
        up_valid = (state == FULL);
    end

    // Payload, tag and priority pointer update on child transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            up_data    <= '0;
            up_src     <= '0;
            last_grant <= LAST_IDX;
        end else if (child_xfer) begin
            up_data    <= win_data;
            up_src     <= win_idx;
            last_grant <= win_idx;
        end
    end

    assign cnt_next = (fwd_count == CNT_MAX) ? fwd_count
                                             : fwd_count + CNT_W'(1);

    // Saturating forward counter with sticky saturation flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_count <= '0;
            fwd_sat   <= 1'b0;
        end else if (up_xfer) begin
            fwd_count <= cnt_next;
            if (cnt_next == CNT_MAX) begin
                fwd_sat <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_subtree_report_collector.sv
// Bench for subtree_report_collector: directed scenarios checked
// against a cycle-level reference model and literal expectations.
module tb_subtree_report_collector;

    localparam int N  = 5;
    localparam int DW = 16;
    localparam int IW = 3;
    localparam int CW = 4;
    localparam int CMAX = 15;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    child_valid;
    logic [N*DW-1:0] child_data;
    logic [N-1:0]    child_ready;
    logic            up_valid;
    logic [DW-1:0]   up_data;
    logic [IW-1:0]   up_src;
    logic            up_ready;
    logic [CW-1:0]   fwd_count;
    logic            fwd_sat;

    logic [DW-1:0]   cdata [N];

    int errors = 0;
    int checks = 0;

    subtree_report_collector #(
        .NUM_CHILD(N),
        .DATA_W(DW),
        .IDX_W(IW),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .child_valid(child_valid),
        .child_data(child_data),
        .child_ready(child_ready),
        .up_valid(up_valid),
        .up_data(up_data),
        .up_src(up_src),
        .up_ready(up_ready),
        .fwd_count(fwd_count),
        .fwd_sat(fwd_sat)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            child_data[i*DW +: DW] = cdata[i];
        end
    end

    function automatic void chk(input string name,
                                input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Reference model state
    bit          m_live = 1'b0;
    bit          m_valid;
    logic [15:0] m_data;
    int          m_src;
    int          m_cnt;
    bit          m_sat;
    int          m_last;

    function automatic int m_winner(input logic [N-1:0] v,
                                    input int last);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (last + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        bit upx;
        bit lok;
        int w;
        if (rst) begin
            m_live  = 1'b1;
            m_valid = 1'b0;
            m_data  = '0;
            m_src   = 0;
            m_cnt   = 0;
            m_sat   = 1'b0;
            m_last  = N - 1;
        end else if (m_live) begin
            upx = m_valid && up_ready;
            lok = !m_valid || up_ready;
            w   = m_winner(child_valid, m_last);
            if (upx) begin
                if (m_cnt < CMAX) m_cnt = m_cnt + 1;
                if (m_cnt == CMAX) m_sat = 1'b1;
            end
            if (w >= 0 && lok) begin
                m_data  = cdata[w];
                m_src   = w;
                m_valid = 1'b1;
                m_last  = w;
            end else if (upx) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        int w;
        logic [N-1:0] er;
        if (m_live) begin
            w  = m_winner(child_valid, m_last);
            er = '0;
            if (w >= 0 && (!m_valid || up_ready)) er[w] = 1'b1;
            chk("m_up_valid", 32'(up_valid), 32'(m_valid));
            chk("m_up_data", 32'(up_data), 32'(m_data));
            chk("m_up_src", 32'(up_src), 32'(m_src));
            chk("m_fwd_count", 32'(fwd_count), 32'(m_cnt));
            chk("m_fwd_sat", 32'(fwd_sat), 32'(m_sat));
            chk("m_child_ready", 32'(child_ready), 32'(er));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    int srcs [$];
    int datas [$];
    int log2 [$];
    logic [N-1:0] hs;
    bit found;

    initial begin
        rst = 1'b1;
        child_valid = '0;
        up_ready = 1'b0;
        for (int i = 0; i < N; i++) cdata[i] = '0;

        // Reset state
        tick();
        tick();
        at_neg();
        chk("rst_up_valid", 32'(up_valid), 0);
        chk("rst_up_data", 32'(up_data), 0);
        chk("rst_up_src", 32'(up_src), 0);
        chk("rst_fwd_count", 32'(fwd_count), 0);
        chk("rst_fwd_sat", 32'(fwd_sat), 0);
        tick();
        rst = 1'b0;

        // Single child 2
        cdata[2] = 16'hA5A5;
        child_valid = 5'b00100;
        up_ready = 1'b1;
        at_neg();
        chk("single_ready", 32'(child_ready), 32'h04);
        tick();
        child_valid = '0;
        at_neg();
        chk("single_valid", 32'(up_valid), 1);
        chk("single_data", 32'(up_data), 32'hA5A5);
        chk("single_src", 32'(up_src), 2);
        tick();
        at_neg();
        chk("single_cnt", 32'(fwd_count), 1);
        chk("single_drain", 32'(up_valid), 0);

        // All children valid, round robin
        do_reset();
        for (int i = 0; i < N; i++) cdata[i] = {4'(i), 12'h000};
        child_valid = '1;
        up_ready = 1'b1;
        srcs.delete();
        datas.delete();
        for (int c = 0; c < 12; c++) begin
            at_neg();
            if (up_valid) begin
                srcs.push_back(int'(up_src));
                datas.push_back(int'(up_data));
            end
            hs = child_ready & child_valid;
            tick();
            for (int i = 0; i < N; i++) begin
                if (hs[i]) cdata[i] = cdata[i] + 16'd1;
            end
        end
        chk("rr_count", srcs.size(), 11);
        for (int n = 0; n < 10; n++) begin
            chk("rr_src", srcs[n], n % N);
            chk("rr_data", datas[n], {16'd0, 4'(n % N), 12'(n / N)});
        end

        // Backpressure
        do_reset();
        child_valid = 5'b00010;
        cdata[1] = 16'h1234;
        up_ready = 1'b0;
        tick();
        cdata[1] = 16'h5678;
        for (int c = 0; c < 4; c++) begin
            at_neg();
            chk("bp_data", 32'(up_data), 32'h1234);
            chk("bp_src", 32'(up_src), 1);
            chk("bp_ready", 32'(child_ready), 0);
            tick();
        end
        up_ready = 1'b1;
        at_neg();
        chk("bp_refill_ready", 32'(child_ready), 32'h02);
        tick();
        child_valid = '0;
        at_neg();
        chk("bp_refill_valid", 32'(up_valid), 1);
        chk("bp_refill_data", 32'(up_data), 32'h5678);
        chk("bp_refill_cnt", 32'(fwd_count), 1);
        tick();

        // Fairness between children 1 and 3, then child 0 joins
        do_reset();
        child_valid = 5'b01010;
        up_ready = 1'b1;
        srcs.delete();
        for (int c = 0; c < 8; c++) begin
            at_neg();
            if (up_valid) srcs.push_back(int'(up_src));
            tick();
        end
        for (int n = 0; n < 6; n++) begin
            chk("fair_alt", srcs[n], (n % 2 == 0) ? 1 : 3);
        end
        child_valid = 5'b01011;
        log2.delete();
        for (int c = 0; c < 7; c++) begin
            at_neg();
            if (up_valid) log2.push_back(int'(up_src));
            tick();
        end
        found = 1'b0;
        for (int n = 1; n <= N && n < log2.size(); n++) begin
            if (log2[n] == 0) found = 1'b1;
        end
        chk("fair_child0", 32'(found), 1);

        // Reset mid-stream
        do_reset();
        child_valid = '1;
        up_ready = 1'b1;
        for (int c = 0; c < 8; c++) tick();
        at_neg();
        chk("mid_cnt7", 32'(fwd_count), 7);
        chk("mid_valid", 32'(up_valid), 1);
        rst = 1'b1;
        child_valid = 5'b10100;
        tick();
        at_neg();
        chk("mid_rst_valid", 32'(up_valid), 0);
        chk("mid_rst_cnt", 32'(fwd_count), 0);
        chk("mid_rst_ready", 32'(child_ready), 32'h04);
        rst = 1'b0;
        tick();
        at_neg();
        chk("mid_first_src", 32'(up_src), 2);
        chk("mid_first_valid", 32'(up_valid), 1);

        // Counter saturation
        do_reset();
        cdata[0] = 16'h00C0;
        child_valid = 5'b00001;
        up_ready = 1'b1;
        for (int i = 0; i < 22; i++) begin
            int e;
            at_neg();
            e = (i < 1) ? 0 : ((i - 1 > CMAX) ? CMAX : i - 1);
            chk("sat_cnt", 32'(fwd_count), e);
            chk("sat_flag", 32'(fwd_sat), (e == CMAX) ? 1 : 0);
            tick();
        end
        at_neg();
        chk("sat_final_cnt", 32'(fwd_count), 15);
        chk("sat_final_flag", 32'(fwd_sat), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
